axi_arbiter_stom_s3: RTL and testbench

Slave-to-master response arbiter for the AXI interconnect: shares one master's R (read-data) and B (write-response) channels among NUM slave ports, typically two real slaves plus the default slave. It complements the master-to-slave request arbiter. Each grant is held until the response burst completes, so R beats of different slaves never interleave on the master port. Round-robin fairness is selectable at compile time.

---
 rtl/axi_arbiter_stom_s3_pkg.sv | 42 ++++
 rtl/axi_arbiter_stom_s3_if.sv | 28 ++
 rtl/axi_arbiter_stom_s3_ch.sv | 95 +++++++++
 rtl/axi_arbiter_stom_s3.sv | 34 +++
 tb/tb_axi_arbiter_stom_s3.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/axi_arbiter_stom_s3_pkg.sv
// Shared constants and selection functions for the slave-to-master response arbiter.
// Round-robin selection is enabled by defining AXI_ARB_STOM_RR_EN.
package axi_arbiter_stom_pkg;

    localparam int unsigned MAX_NUM   = 16;
    localparam int unsigned MAX_IDX_W = 4;

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_BUSY = 1'b1;

    // Round-robin pick: first set bit searching upward from last_idx+1, modulo num.
    function automatic logic [MAX_NUM-1:0] rr_sel(
        input logic [MAX_NUM-1:0]   req,
        input logic [MAX_IDX_W-1:0] last_idx,
        input int unsigned          num
    );
        logic [MAX_IDX_W-1:0] idx;
        rr_sel = '0;
        // Walk the search order backwards so the nearest candidate is written last.
        for (int k = int'(num); k >= 1; k--) begin
            idx = MAX_IDX_W'((int'(last_idx) + k) % int'(num));
            if (req[idx]) begin
                rr_sel = MAX_NUM'(1) << idx;
            end
        end
    endfunction

    // Fixed priority pick: lowest set index wins.
    function automatic logic [MAX_NUM-1:0] pri_sel(
        input logic [MAX_NUM-1:0] req
    );
        logic [MAX_IDX_W-1:0] idx;
        pri_sel = '0;
        for (int i = int'(MAX_NUM) - 1; i >= 0; i--) begin
            idx = MAX_IDX_W'(i);
            if (req[idx]) begin
                pri_sel = MAX_NUM'(1) << idx;
            end
        end
    endfunction

endpackage

// File: rtl/axi_arbiter_stom_s3_if.sv
// Request/grant bundle between the slave-side R/B channels and the response arbiter.
interface axi_arbiter_stom_s3_if #(
    parameter int unsigned NUM = 3
);
    logic [NUM-1:0] RSELECT;
    logic [NUM-1:0] RVALID;
    logic [NUM-1:0] RLAST;
    logic           RREADY;
    logic [NUM-1:0] RGRANT;
    logic [NUM-1:0] BSELECT;
    logic [NUM-1:0] BVALID;
    logic           BREADY;
    logic [NUM-1:0] BGRANT;

    // Driver side: the slaves and the master's ready signals.
    modport master (
        output RSELECT, RVALID, RLAST, RREADY,
        output BSELECT, BVALID, BREADY,
        input  RGRANT, BGRANT
    );

    // Arbiter side.
    modport slave (
        input  RSELECT, RVALID, RLAST, RREADY,
        input  BSELECT, BVALID, BREADY,
        output RGRANT, BGRANT
    );
endinterface

// File: rtl/axi_arbiter_stom_s3_ch.sv
// One response channel: grant FSM, held grant and selection pointer.
// Round-robin pointer exists only when AXI_ARB_STOM_RR_EN is defined.
module axi_arbiter_stom_ch
    import axi_arbiter_stom_pkg::*;
#(
    parameter int unsigned NUM = 3
) (
    input  logic           ACLK,
    input  logic           ARESETn,
    input  logic [NUM-1:0] select,
    input  logic [NUM-1:0] valid,
    input  logic [NUM-1:0] last,
    input  logic           ready,
    output logic [NUM-1:0] grant
);

    logic           state_q;
    logic           state_d;
    logic [NUM-1:0] req;
    logic [NUM-1:0] sel_grant;
    logic [NUM-1:0] grant_reg;
    logic           done;

    assign req  = select & valid;
    assign done = (|(grant & valid & last)) & ready;

`ifdef AXI_ARB_STOM_RR_EN
    localparam int unsigned IW = (NUM > 1) ? $clog2(NUM) : 1;

    logic [IW-1:0] last_idx;
    logic [IW-1:0] done_idx;

    assign sel_grant = NUM'(rr_sel(MAX_NUM'(req), MAX_IDX_W'(last_idx), NUM));

    always_comb begin
        done_idx = '0;
        for (int i = 0; i < int'(NUM); i++) begin
            if (grant[i]) begin
                done_idx = IW'(i);
            end
        end
    end

    // Pointer remembers the most recently completed grant.
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            last_idx <= IW'(NUM - 1);
        end else if (done) begin
            last_idx <= done_idx;
        end
    end
`else
    assign sel_grant = NUM'(pri_sel(MAX_NUM'(req)));
`endif

    // State register.
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if ((|grant) && !done) state_d = ST_BUSY;
            ST_BUSY: if (done)              state_d = ST_IDLE;
        endcase
    end

    // Grant output: combinational in IDLE, held in BUSY, zero under reset.
    always_comb begin
        grant = '0;
        if (ARESETn) begin
            case (state_q)
                ST_IDLE: grant = sel_grant;
                ST_BUSY: grant = grant_reg;
            endcase
        end
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            grant_reg <= '0;
        end else if ((state_q == ST_IDLE) && (state_d == ST_BUSY)) begin
            grant_reg <= grant;
        end else if ((state_q == ST_BUSY) && done) begin
            grant_reg <= '0;
        end
    end

endmodule

// File: rtl/axi_arbiter_stom_s3.sv
// Slave-to-master response arbiter: independent R and B grant channels for one master.
// Define AXI_ARB_STOM_RR_EN for round-robin; otherwise lowest index wins.
module axi_arbiter_stom_s3
    import axi_arbiter_stom_pkg::*;
#(
    parameter int unsigned NUM = 3
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,
    axi_arbiter_stom_s3_if.slave  bus
);

    axi_arbiter_stom_ch #(.NUM(NUM)) u_r_ch (
        .ACLK    (ACLK),
        .ARESETn (ARESETn),
        .select  (bus.RSELECT),
        .valid   (bus.RVALID),
        .last    (bus.RLAST),
        .ready   (bus.RREADY),
        .grant   (bus.RGRANT)
    );

    // Write responses are single beats, so every B beat is last.
    axi_arbiter_stom_ch #(.NUM(NUM)) u_b_ch (
        .ACLK    (ACLK),
        .ARESETn (ARESETn),
        .select  (bus.BSELECT),
        .valid   (bus.BVALID),
        .last    ({NUM{1'b1}}),
        .ready   (bus.BREADY),
        .grant   (bus.BGRANT)
    );

endmodule

// File: tb/tb_axi_arbiter_stom_s3.sv
// Bench for axi_arbiter_stom_s3 (NUM=3): directed vector table, hand sequence, random vs model.
module tb_axi_arbiter_stom_s3;

    localparam int unsigned N = 3;
`ifdef AXI_ARB_STOM_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    typedef struct packed {
        logic       rst_n;
        logic [2:0] rsel;
        logic [2:0] rvalid;
        logic [2:0] rlast;
        logic       rready;
        logic [2:0] bsel;
        logic [2:0] bvalid;
        logic       bready;
        logic [2:0] exp_r;
        logic [2:0] exp_b;
    } vec_t;

    logic ACLK;
    logic ARESETn;

    axi_arbiter_stom_s3_if #(.NUM(N)) bus ();

    axi_arbiter_stom_s3 #(.NUM(N)) dut (
        .ACLK    (ACLK),
        .ARESETn (ARESETn),
        .bus     (bus.slave)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference state: current owner (-1 = free) and last completed index per channel.
    int r_owner = -1;
    int r_ptr   = N - 1;
    int b_owner = -1;
    int b_ptr   = N - 1;

    vec_t vecs[28];

    function automatic vec_t mk(logic rst, logic [2:0] rs, logic [2:0] rv, logic [2:0] rl, logic rr,
                                logic [2:0] bs, logic [2:0] bv, logic br,
                                logic [2:0] er, logic [2:0] eb);
        vec_t v;
        v = '{rst, rs, rv, rl, rr, bs, bv, br, er, eb};
        return v;
    endfunction

    function automatic logic [2:0] model_grant(int owner, int ptr, logic [2:0] req);
        int i;
        if (owner >= 0) return 3'(1 << owner);
        for (int k = 1; k <= int'(N); k++) begin
            i = (ptr + k) % int'(N);
            if (req[i]) return 3'(1 << i);
        end
        return 3'b000;
    endfunction

    task automatic model_step(input logic [2:0] g, input logic [2:0] v, input logic [2:0] l,
                              input logic rdy, inout int owner, inout int ptr);
        int idx;
        if (g == 3'b000) return;
        idx = (g[0]) ? 0 : (g[1]) ? 1 : 2;
        if (v[idx] && l[idx] && rdy) begin
            owner = -1;
            if (RR) ptr = idx;
        end else begin
            owner = idx;
        end
    endtask

    task automatic check(input string nm, input logic [2:0] act, input logic [2:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b required %b (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input vec_t v);
        ARESETn     = v.rst_n;
        bus.RSELECT = v.rsel;
        bus.RVALID  = v.rvalid;
        bus.RLAST   = v.rlast;
        bus.RREADY  = v.rready;
        bus.BSELECT = v.bsel;
        bus.BVALID  = v.bvalid;
        bus.BREADY  = v.bready;
    endtask

    // Sample on the falling edge, check, then advance the model across the rising edge.
    task automatic run_cycle(input bit chk, input logic [2:0] er, input logic [2:0] eb, input string nm);
        logic       rst_s, rr, br;
        logic [2:0] rs, rv, rl, bs, bv, mr, mb;
        @(negedge ACLK);
        rst_s = ARESETn;
        rs = bus.RSELECT; rv = bus.RVALID; rl = bus.RLAST; rr = bus.RREADY;
        bs = bus.BSELECT; bv = bus.BVALID; br = bus.BREADY;
        mr = rst_s ? model_grant(r_owner, r_ptr, rs & rv) : 3'b000;
        mb = rst_s ? model_grant(b_owner, b_ptr, bs & bv) : 3'b000;
        check({nm, "_rgrant_model"}, bus.RGRANT, mr);
        check({nm, "_bgrant_model"}, bus.BGRANT, mb);
        if (chk) begin
            check({nm, "_rgrant"}, bus.RGRANT, er);
            check({nm, "_bgrant"}, bus.BGRANT, eb);
        end
        @(posedge ACLK);
        if (!rst_s) begin
            r_owner = -1; r_ptr = N - 1;
            b_owner = -1; b_ptr = N - 1;
        end else begin
            model_step(mr, rv, rl, rr, r_owner, r_ptr);
            model_step(mb, bv, 3'b111, br, b_owner, b_ptr);
        end
        #1;
    endtask

    initial begin
        vec_t v;
        // Reset with all slaves requesting, then first grant after release.
        vecs[0]  = mk(0, 3'b111, 3'b111, 3'b111, 0, 3'b000, 3'b000, 1, 3'b000, 3'b000);
        vecs[1]  = mk(0, 3'b111, 3'b111, 3'b111, 0, 3'b000, 3'b000, 1, 3'b000, 3'b000);
        vecs[2]  = mk(1, 3'b111, 3'b111, 3'b111, 0, 3'b000, 3'b000, 1, 3'b001, 3'b000);
        vecs[3]  = mk(1, 3'b111, 3'b111, 3'b111, 1, 3'b000, 3'b000, 1, 3'b001, 3'b000);
        vecs[4]  = mk(0, 3'b000, 3'b000, 3'b000, 1, 3'b000, 3'b000, 1, 3'b000, 3'b000);
        // Slave 1 four-beat burst with a stall; slave 0 waits.
        vecs[5]  = mk(1, 3'b011, 3'b010, 3'b000, 1, 3'b000, 3'b000, 1, 3'b010, 3'b000);
        vecs[6]  = mk(1, 3'b011, 3'b011, 3'b000, 0, 3'b000, 3'b000, 1, 3'b010, 3'b000);
        vecs[7]  = mk(1, 3'b011, 3'b011, 3'b000, 1, 3'b000, 3'b000, 1, 3'b010, 3'b000);
        vecs[8]  = mk(1, 3'b011, 3'b011, 3'b000, 1, 3'b000, 3'b000, 1, 3'b010, 3'b000);
        vecs[9]  = mk(1, 3'b011, 3'b011, 3'b010, 1, 3'b000, 3'b000, 1, 3'b010, 3'b000);
        vecs[10] = mk(1, 3'b011, 3'b001, 3'b001, 1, 3'b000, 3'b000, 1, 3'b001, 3'b000);
        // Continuous single beats from all three slaves.
        vecs[11] = mk(0, 3'b000, 3'b000, 3'b000, 1, 3'b000, 3'b000, 1, 3'b000, 3'b000);
        vecs[12] = mk(1, 3'b111, 3'b111, 3'b111, 1, 3'b000, 3'b000, 1, 3'b001, 3'b000);
        vecs[13] = mk(1, 3'b111, 3'b111, 3'b111, 1, 3'b000, 3'b000, 1, RR ? 3'b010 : 3'b001, 3'b000);
        vecs[14] = mk(1, 3'b111, 3'b111, 3'b111, 1, 3'b000, 3'b000, 1, RR ? 3'b100 : 3'b001, 3'b000);
        vecs[15] = mk(1, 3'b111, 3'b111, 3'b111, 1, 3'b000, 3'b000, 1, 3'b001, 3'b000);
        // VALID without SELECT is never granted.
        vecs[16] = mk(1, 3'b011, 3'b100, 3'b100, 1, 3'b000, 3'b000, 1, 3'b000, 3'b000);
        vecs[17] = mk(1, 3'b011, 3'b100, 3'b100, 1, 3'b000, 3'b000, 1, 3'b000, 3'b000);
        vecs[18] = mk(1, 3'b011, 3'b001, 3'b001, 1, 3'b000, 3'b000, 1, 3'b001, 3'b000);
        // B arbitration while R is busy on slave 1.
        vecs[19] = mk(0, 3'b000, 3'b000, 3'b000, 1, 3'b000, 3'b000, 1, 3'b000, 3'b000);
        vecs[20] = mk(1, 3'b010, 3'b010, 3'b000, 1, 3'b101, 3'b101, 1, 3'b010, 3'b001);
        vecs[21] = mk(1, 3'b010, 3'b010, 3'b000, 1, 3'b101, 3'b100, 1, 3'b010, 3'b100);
        vecs[22] = mk(1, 3'b010, 3'b010, 3'b010, 1, 3'b000, 3'b000, 1, 3'b010, 3'b000);
        // Reset mid-burst on slave 2.
        vecs[23] = mk(1, 3'b100, 3'b100, 3'b000, 1, 3'b000, 3'b000, 1, 3'b100, 3'b000);
        vecs[24] = mk(1, 3'b100, 3'b100, 3'b000, 1, 3'b000, 3'b000, 1, 3'b100, 3'b000);
        vecs[25] = mk(0, 3'b100, 3'b100, 3'b000, 1, 3'b000, 3'b000, 1, 3'b000, 3'b000);
        vecs[26] = mk(1, 3'b001, 3'b001, 3'b001, 1, 3'b000, 3'b000, 1, 3'b001, 3'b000);
        vecs[27] = mk(1, 3'b000, 3'b000, 3'b000, 1, 3'b000, 3'b000, 1, 3'b000, 3'b000);

        drive(vecs[0]);
        for (int i = 0; i < 28; i++) begin
            drive(vecs[i]);
            run_cycle(1'b1, vecs[i].exp_r, vecs[i].exp_b, $sformatf("vec%0d", i));
        end

        // Hand sequence: R and B complete together, pointers advance independently.
        drive(mk(0, 3'b000, 3'b000, 3'b000, 1, 3'b000, 3'b000, 1, 3'b000, 3'b000));
        run_cycle(1'b1, 3'b000, 3'b000, "both_rst");
        drive(mk(1, 3'b001, 3'b001, 3'b001, 1, 3'b010, 3'b010, 1, 3'b000, 3'b000));
        run_cycle(1'b1, 3'b001, 3'b010, "both_done");
        drive(mk(1, 3'b111, 3'b111, 3'b111, 1, 3'b111, 3'b111, 1, 3'b000, 3'b000));
        run_cycle(1'b1, RR ? 3'b010 : 3'b001, RR ? 3'b100 : 3'b001, "both_next");

        // Randomized traffic against the reference model.
        for (int c = 0; c < 3000; c++) begin
            v.rst_n  = ($urandom_range(63) != 0);
            v.rsel   = 3'($urandom);
            v.rvalid = 3'($urandom);
            v.rlast  = 3'($urandom) & 3'($urandom);
            v.rready = ($urandom_range(3) != 0);
            v.bsel   = 3'($urandom);
            v.bvalid = 3'($urandom);
            v.bready = ($urandom_range(3) != 0);
            v.exp_r  = 3'b000;
            v.exp_b  = 3'b000;
            drive(v);
            run_cycle(1'b0, 3'b000, 3'b000, "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
